// File: rtl/rbi_demux_if.sv
// rbi_demux_if: groups the manager-side and subordinate-side RBI signals of
// rbi_demux into one bundle.
//   m_*      : single manager port (addr/wdata/mask/enables in, acks/err/rdata out)
//   s_*      : NUM_SUBS subordinate ports; addr/wdata/mask shared, enables,
//              acks and errors one bit per subordinate, rdata packed
//   busy     : demux is not idle
//   timeout  : one-cycle pulse when a forwarded transaction times out
// Modport "slave" is the demux's view, "master" is the view of whatever
// drives the manager requests and plays the subordinates.
interface rbi_demux_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SUBS       = 4,
  parameter int SUB_ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]          m_addr;
  logic                           m_write_en;
  logic [DATA_WIDTH-1:0]          m_wdata;
  logic [DATA_WIDTH-1:0]          m_wbit_mask;
  logic                           m_write_ack;
  logic                           m_write_err;
  logic                           m_read_en;
  logic                           m_read_ack;
  logic [DATA_WIDTH-1:0]          m_rdata;
  logic                           m_read_err;

  logic [SUB_ADDR_WIDTH-1:0]      s_addr;
  logic [DATA_WIDTH-1:0]          s_wdata;
  logic [DATA_WIDTH-1:0]          s_wbit_mask;
  logic [NUM_SUBS-1:0]            s_write_en;
  logic [NUM_SUBS-1:0]            s_write_ack;
  logic [NUM_SUBS-1:0]            s_write_err;
  logic [NUM_SUBS-1:0]            s_read_en;
  logic [NUM_SUBS-1:0]            s_read_ack;
  logic [NUM_SUBS*DATA_WIDTH-1:0] s_rdata;
  logic [NUM_SUBS-1:0]            s_read_err;

  logic                           busy;
  logic                           timeout;

  modport slave (
    input  m_addr, m_write_en, m_wdata, m_wbit_mask, m_read_en,
    output m_write_ack, m_write_err, m_read_ack, m_rdata, m_read_err,
    output s_addr, s_wdata, s_wbit_mask, s_write_en, s_read_en,
    input  s_write_ack, s_write_err, s_read_ack, s_rdata, s_read_err,
    output busy, timeout
  );

  modport master (
    output m_addr, m_write_en, m_wdata, m_wbit_mask, m_read_en,
    input  m_write_ack, m_write_err, m_read_ack, m_rdata, m_read_err,
    input  s_addr, s_wdata, s_wbit_mask, s_write_en, s_read_en,
    output s_write_ack, s_write_err, s_read_ack, s_rdata, s_read_err,
    input  busy, timeout
  );
endinterface

// File: rtl/rbi_demux.sv
// rbi_demux: fans one RBI manager port out to NUM_SUBS subordinates using
// fixed 2^SUB_ADDR_WIDTH-byte windows starting at BASE_ADDR. One transaction
// is in flight at a time; out-of-window requests get an error response and
// a subordinate that never acks is abandoned after TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rbi_demux_if.slave (manager side, subordinate side, busy,
//                timeout)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a manager request
// FWD   | s_*_en[idx] asserted, waiting for that subordinate's ack
// RESP  | single cycle presenting the registered ack/err/rdata to manager
module rbi_demux #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SUBS       = 4,
  parameter int                    SUB_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  rbi_demux_if.slave bus
);

  localparam int IDX_W   = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SUB_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     mask_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      is_wr_q;

  logic                      write_ack_q, write_err_q;
  logic                      read_ack_q, read_err_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      timeout_q;

  logic                      load;
  logic                      resp_wr, resp_rd, resp_err, resp_to;
  logic [DATA_WIDTH-1:0]     resp_data;

  // Address decode. A wrap in the subtraction only happens below BASE_ADDR,
  // which the >= test already rejects.
  logic [ADDR_WIDTH-1:0] off, off_hi;
  logic                  hit;

  assign off    = bus.m_addr - BASE_ADDR;
  assign off_hi = off >> SUB_ADDR_WIDTH;
  assign hit    = (bus.m_addr >= BASE_ADDR) && (off_hi < ADDR_WIDTH'(NUM_SUBS));

  // Selected subordinate's response; acks on other indices never reach the FSM.
  logic                  sel_wack, sel_werr, sel_rack, sel_rerr, sel_ack;
  logic [DATA_WIDTH-1:0] sel_rdata;

  always_comb begin
    sel_wack  = 1'b0;
    sel_werr  = 1'b0;
    sel_rack  = 1'b0;
    sel_rerr  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SUBS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_wack  = bus.s_write_ack[i];
        sel_werr  = bus.s_write_err[i];
        sel_rack  = bus.s_read_ack[i];
        sel_rerr  = bus.s_read_err[i];
        sel_rdata = bus.s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_ack = is_wr_q ? sel_wack : sel_rack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    resp_wr   = 1'b0;
    resp_rd   = 1'b0;
    resp_err  = 1'b0;
    resp_to   = 1'b0;
    resp_data = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.m_write_en || bus.m_read_en) begin
          load = 1'b1;
          if (bus.m_write_en && bus.m_read_en) begin
            // Ambiguous request: answer both sides with an error, touch nothing.
            state_d  = RESP;
            resp_wr  = 1'b1;
            resp_rd  = 1'b1;
            resp_err = 1'b1;
          end else if (hit) begin
            state_d = FWD;
          end else begin
            state_d  = RESP;
            resp_wr  = bus.m_write_en;
            resp_rd  = bus.m_read_en;
            resp_err = 1'b1;
          end
        end
      end
      FWD: begin
        if (sel_ack) begin
          state_d   = RESP;
          resp_wr   = is_wr_q;
          resp_rd   = !is_wr_q;
          resp_err  = is_wr_q ? sel_werr : sel_rerr;
          resp_data = is_wr_q ? '0 : sel_rdata;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == CNT_W'(TO_LAST)) begin
            state_d  = RESP;
            resp_wr  = is_wr_q;
            resp_rd  = !is_wr_q;
            resp_err = 1'b1;
            resp_to  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      is_wr_q     <= 1'b0;
      write_ack_q <= 1'b0;
      write_err_q <= 1'b0;
      read_ack_q  <= 1'b0;
      read_err_q  <= 1'b0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        addr_q  <= off[SUB_ADDR_WIDTH-1:0];
        wdata_q <= bus.m_wdata;
        mask_q  <= bus.m_wbit_mask;
        idx_q   <= off_hi[IDX_W-1:0];
        is_wr_q <= bus.m_write_en;
      end
      // Response flops are loaded only on entry to RESP, so they read 0
      // in every other cycle.
      write_ack_q <= resp_wr;
      write_err_q <= resp_wr && resp_err;
      read_ack_q  <= resp_rd;
      read_err_q  <= resp_rd && resp_err;
      rdata_q     <= resp_data;
      timeout_q   <= resp_to;
    end
  end

  // Enables decode straight from the state register so an async reset
  // drops them immediately.
  logic [NUM_SUBS-1:0] wen, ren;

  always_comb begin
    wen = '0;
    ren = '0;
    for (int i = 0; i < NUM_SUBS; i++) begin
      wen[i] = (state_q == FWD) && is_wr_q  && (idx_q == IDX_W'(i));
      ren[i] = (state_q == FWD) && !is_wr_q && (idx_q == IDX_W'(i));
    end
  end

  assign bus.s_write_en  = wen;
  assign bus.s_read_en   = ren;
  assign bus.s_addr      = addr_q;
  assign bus.s_wdata     = wdata_q;
  assign bus.s_wbit_mask = mask_q;

  assign bus.m_write_ack = write_ack_q;
  assign bus.m_write_err = write_err_q;
  assign bus.m_read_ack  = read_ack_q;
  assign bus.m_read_err  = read_err_q;
  assign bus.m_rdata     = rdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout     = timeout_q;

endmodule

// File: doc/rbi_demux.md
Name: rbi_demux

Overview:
- Parametrised RBI fabric block: one RBI manager-side port fans out to NUM_SUBS subordinate-side ports.
- Fixed-size contiguous address windows select the target subordinate.
- Adds behaviour a point-to-point RBI link lacks: decode-error response, per-transaction timeout and a single-outstanding-transaction FSM.
- Sits between a bus bridge/CPU manager and several register banks.

Parameters:
ADDR_WIDTH, 32, manager address width
DATA_WIDTH, 32, data/mask width
NUM_SUBS, 4, number of subordinate ports (1..16)
SUB_ADDR_WIDTH, 12, window size per subordinate = 2^SUB_ADDR_WIDTH bytes; must be < ADDR_WIDTH
BASE_ADDR, 0, start address of window 0 (aligned to 2^SUB_ADDR_WIDTH)
TIMEOUT_CYCLES, 255, max cycles waiting for subordinate ack; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_addr  in  ADDR_WIDTH  manager address
m_write_en  in  1  write request
m_wdata  in  DATA_WIDTH  write data
m_wbit_mask  in  DATA_WIDTH  per-bit write mask
m_write_ack  out  1  write done pulse
m_write_err  out  1  write error, valid with m_write_ack
m_read_en  in  1  read request
m_read_ack  out  1  read done pulse
m_rdata  out  DATA_WIDTH  read data, valid with m_read_ack
m_read_err  out  1  read error, valid with m_read_ack
s_addr  out  SUB_ADDR_WIDTH  window offset, shared by all subordinates
s_wdata  out  DATA_WIDTH  shared write data
s_wbit_mask  out  DATA_WIDTH  shared write mask
s_write_en  out  NUM_SUBS  per-subordinate write request
s_write_ack  in  NUM_SUBS  per-subordinate write ack
s_write_err  in  NUM_SUBS  per-subordinate write error
s_read_en  out  NUM_SUBS  per-subordinate read request
s_read_ack  in  NUM_SUBS  per-subordinate read ack
s_rdata  in  NUM_SUBS*DATA_WIDTH  packed read data, sub i at [i*DATA_WIDTH +: DATA_WIDTH]
s_read_err  in  NUM_SUBS  per-subordinate read error
busy  out  1  high when not IDLE
timeout  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset: one clock, async active-low reset on clk/rst_n (fixed). All outputs 0; FSM in IDLE; counter 0. Reset mid-transaction drops it silently: no manager ack, subordinate enables go low immediately.
- Protocol:
  - Manager holds en/addr/wdata/mask stable until it samples its ack, then drops en the next cycle.
  - Subordinate holds ack high for exactly one cycle; ack may be combinational in the first en cycle.
- Decode:
  - off = m_addr - BASE_ADDR; idx = off >> SUB_ADDR_WIDTH.
  - Hit when m_addr >= BASE_ADDR and idx < NUM_SUBS.
  - s_addr = off[SUB_ADDR_WIDTH-1:0].
- FSM IDLE -> FWD -> RESP -> IDLE:
  - IDLE: on write_en xor read_en, register addr/data/mask/idx/kind.
    - Hit -> FWD; next cycle drive s_*_en[idx]=1 (one-hot) and shared s_* outputs.
    - Miss -> RESP with err=1.
    - write_en and read_en both high -> RESP; both ack and err pulses asserted; no subordinate access.
  - FWD: hold s_*_en[idx] until s_*_ack[idx] sampled high. Capture err and rdata slice; -> RESP; s_*_en deasserts the next cycle. Acks on non-selected indices are ignored.
  - Timeout: counter increments each FWD cycle. On reaching TIMEOUT_CYCLES without ack -> RESP with err=1, rdata=0, timeout pulse; s_*_en dropped. A late ack arriving after this is ignored.
  - RESP: exactly one cycle. m_*_ack=1 with captured err; m_rdata = captured data on reads, else 0 → IDLE.
- Latency, request to manager ack:
  - Hit with combinational sub ack: 2 cycles.
  - Decode error: 1 cycle.
  - Timeout: TIMEOUT_CYCLES+1 cycles.
- Requests arriving while not IDLE are not sampled; manager must wait for ack. Back-to-back requests are accepted on the cycle after RESP.
- m_rdata, m_*_err and m_*_ack are registered; all are 0 outside RESP.

Test Plan:
(NUM_SUBS=4, SUB_ADDR_WIDTH=12, BASE_ADDR=0x1000_0000, TIMEOUT_CYCLES=16)
- Write 0x1000_2010, wdata 0xDEAD_BEEF, mask 0xFFFF_0000; sub2 acks the same cycle -> s_write_en=4'b0100, s_addr=0x010, mask passed through, m_write_ack 2 cycles after request, err=0.
- Read 0x1000_3FFC; sub3 returns 0x1234_5678 after 3 wait cycles -> m_rdata=0x1234_5678, m_read_ack once, no other s_read_en bit set.
- Read 0x1000_4000 and 0x0FFF_FFFC -> m_read_ack next cycle, m_read_err=1, m_rdata=0, s_read_en stays 0.
- Write to sub1, no ack -> s_write_en[1] high exactly 16 cycles, timeout pulse, m_write_ack+err; late sub1 ack ignored, busy=0.
- Both en high -> both acks and errs pulse together. rst_n low during FWD -> all outputs 0 asynchronously, no ack after release.
- Sub ack on a non-selected index during FWD -> ignored; transaction completes only on the selected sub's ack.
